fa_bist_checker: RTL and testbench
==================================

// Module: fa_bist_checker
// PURPOSE
//  Hardware self-test engine for the full adder: the checking end of the fa interface.
//  - Drives all 8 input vectors into an external fa instance.
//  - Samples s/cout and compares them with a golden model.
//  - Counts mismatches and records the first failing vector.
//  - Sits beside the fa instance and is started by a pulse; it replaces a simulation-only exhaustive bench.
// PARAMETERS
//  SETTLE_CYCLES  1  cycles each vector is held before sampling; legal range >=1
//  ERR_W          4  width of the mismatch counter; the counter saturates
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      1-cycle start pulse; honoured only in IDLE or DONE
//  abort      in   1      synchronous abort; returns the block to IDLE
//  fa_a       out  1      operand a to the fa under test (registered)
//  fa_b       out  1      operand b to the fa under test (registered)
//  fa_cin     out  1      carry-in to the fa under test (registered)
//  fa_s       in   1      sum returned by the fa
//  fa_cout    in   1      carry-out returned by the fa
//  busy       out  1      high in SETTLE or CHECK
//  done       out  1      high in DONE until restart, abort or reset
//  pass       out  1      done && err_cnt==0
//  err_cnt    out  ERR_W  mismatching vectors in the current run; saturates at all-ones
//  fail_valid out  1      set on the first mismatch of a run
//  fail_vec   out  3      {a,b,cin} of the first mismatch; 0 when fail_valid=0
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; vec=0; settle counter=0; every output 0.
//  State machine: IDLE, SETTLE, CHECK, DONE.
//  Vector mapping and order:
//  - {fa_a,fa_b,fa_cin} = vec[2:0].
//  - vec steps 0,1,...,7 (000 to 111).
//  Golden model: exp_s = ^vec; exp_cout = majority(vec[2],vec[1],vec[0]).
//  IDLE/DONE with start=1:
//  - vec, err_cnt, fail_valid, fail_vec, done and the settle counter cleared to 0.
//  - Next state SETTLE.
//  SETTLE: vec held on fa_* for exactly SETTLE_CYCLES cycles, then CHECK.
//  CHECK (1 cycle):
//  - fa_s/fa_cout compared with the golden model.
//  - On mismatch: err_cnt+1 (saturating).
//  - On mismatch with fail_valid=0: fail_vec<=vec and fail_valid<=1.
//  - vec==7 -> DONE; otherwise vec+1 -> SETTLE.
//  Latency: each vector takes SETTLE_CYCLES+1 cycles.
//  - done rises exactly 8*(SETTLE_CYCLES+1) cycles after the edge that accepted start.
//  Boundaries:
//  - start while busy is ignored; the run continues unchanged.
//  - abort (any state) has priority over start:
//    - next state IDLE; fa_*=0 and the settle counter cleared.
//    - err_cnt, fail_* and pass cleared; done cleared.
//  - vec never wraps within a run; 7 is always followed by DONE.
//  - err_cnt stops at 2^ERR_W-1 when there are more mismatches than that.
//  - rst_n low mid-run aborts immediately with all outputs 0.
//  - No restart occurs after rst_n deasserts until a new start.
//  - The fa is treated as combinational. SETTLE_CYCLES covers any external pipelining or registering.
// TESTING
//  T1 correct fa, SETTLE_CYCLES=1, one start pulse:
//     - fa_* steps 000..111; done at cycle 16; pass=1, err_cnt=0, fail_valid=0.
//  T2 fa_s stuck at 0:
//     - err_cnt=4 (vectors 1,2,4,7); fail_vec=3'b001; pass=0.
//  T3 fa_cout stuck at 1:
//     - err_cnt=4 (vectors 0,1,2,4); fail_vec=3'b000; pass=0.
//  T4 fa_s inverted, ERR_W=2: err_cnt saturates at 3; fail_vec=3'b000.
//  T5 SETTLE_CYCLES=3, correct fa, start pulsed again in cycle 5:
//     - Second start ignored; done at cycle 32; pass=1.
//  T6 abort in cycle 6 of a run, then rst_n=0 in cycle 9 of a new run:
//     - Both cases: IDLE, all outputs 0.
//     - A following start completes normally with pass=1.

Source files
------------

// File: rtl/fa_bist_checker.sv
// Self-test engine for a single full adder: walks all eight operand vectors,
// compares the returned sum/carry with a golden model and records errors.
module fa_bist_checker #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [2:0]       fail_vec
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [2:0]       VEC_LAST = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       vec, vec_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [ERR_W-1:0] err_nxt;
  logic             fail_valid_nxt;
  logic [2:0]       fail_vec_nxt;
  logic             busy_nxt, done_nxt, pass_nxt;
  logic             exp_s_c, exp_cout_c, mismatch_c;

  // Operands are driven straight from the vector register.
  assign fa_a   = vec[2];
  assign fa_b   = vec[1];
  assign fa_cin = vec[0];

  // Golden full-adder model.
  assign exp_s_c    = ^vec;
  assign exp_cout_c = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
  assign mismatch_c = (fa_s != exp_s_c) || (fa_cout != exp_cout_c);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort outranks start.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) state_nxt = S_SETTLE;
        S_SETTLE:       if (cnt == CNT_LAST) state_nxt = S_CHECK;
        S_CHECK:        state_nxt = (vec == VEC_LAST) ? S_DONE : S_SETTLE;
        default:        state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath and output next values.
  always_comb begin
    vec_nxt        = vec;
    cnt_nxt        = cnt;
    err_nxt        = err_cnt;
    fail_valid_nxt = fail_valid;
    fail_vec_nxt   = fail_vec;
    if (abort) begin
      vec_nxt        = '0;
      cnt_nxt        = '0;
      err_nxt        = '0;
      fail_valid_nxt = 1'b0;
      fail_vec_nxt   = '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            vec_nxt        = '0;
            cnt_nxt        = '0;
            err_nxt        = '0;
            fail_valid_nxt = 1'b0;
            fail_vec_nxt   = '0;
          end
        end
        S_SETTLE: cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        S_CHECK: begin
          if (mismatch_c) begin
            if (err_cnt != ERR_MAX) err_nxt = err_cnt + ERR_W'(1);
            if (!fail_valid) begin
              fail_valid_nxt = 1'b1;
              fail_vec_nxt   = vec;
            end
          end
          if (vec != VEC_LAST) vec_nxt = vec + 3'd1;
        end
        default: ;
      endcase
    end
    busy_nxt = (state_nxt == S_SETTLE) || (state_nxt == S_CHECK);
    done_nxt = (state_nxt == S_DONE);
    pass_nxt = done_nxt && (err_nxt == '0);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec        <= '0;
      cnt        <= '0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      vec        <= vec_nxt;
      cnt        <= cnt_nxt;
      err_cnt    <= err_nxt;
      fail_valid <= fail_valid_nxt;
      fail_vec   <= fail_vec_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
    end
  end

endmodule

// File: tb/tb_fa_bist_checker.sv
// Directed bench for fa_bist_checker: three instances with behavioural full
// adders that can be switched between correct and faulty behaviour.
module tb_fa_bist_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start, abort;
  logic [2:0] fa_a, fa_b, fa_cin, fa_s, fa_cout;
  logic [2:0] busy, done, pass, fail_valid;
  logic [2:0] fvec0, fvec1, fvec2;
  logic [3:0] err0, err2;
  logic [1:0] err1;
  logic [1:0] mode0, mode1, mode2;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // mode: 0 correct, 1 sum stuck at 0, 2 carry stuck at 1, 3 sum inverted
  function automatic logic [1:0] fa_ref(input logic [1:0] m, input logic a, input logic b, input logic c);
    logic s, co;
    s  = a ^ b ^ c;
    co = (a & b) | (a & c) | (b & c);
    case (m)
      2'd1: s = 1'b0;
      2'd2: co = 1'b1;
      2'd3: s = ~s;
      default: ;
    endcase
    return {co, s};
  endfunction

  assign {fa_cout[0], fa_s[0]} = fa_ref(mode0, fa_a[0], fa_b[0], fa_cin[0]);
  assign {fa_cout[1], fa_s[1]} = fa_ref(mode1, fa_a[1], fa_b[1], fa_cin[1]);
  assign {fa_cout[2], fa_s[2]} = fa_ref(mode2, fa_a[2], fa_b[2], fa_cin[2]);

  fa_bist_checker #(.SETTLE_CYCLES(1), .ERR_W(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .fa_a(fa_a[0]), .fa_b(fa_b[0]), .fa_cin(fa_cin[0]), .fa_s(fa_s[0]), .fa_cout(fa_cout[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_cnt(err0),
    .fail_valid(fail_valid[0]), .fail_vec(fvec0));

  fa_bist_checker #(.SETTLE_CYCLES(1), .ERR_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .fa_a(fa_a[1]), .fa_b(fa_b[1]), .fa_cin(fa_cin[1]), .fa_s(fa_s[1]), .fa_cout(fa_cout[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_cnt(err1),
    .fail_valid(fail_valid[1]), .fail_vec(fvec1));

  fa_bist_checker #(.SETTLE_CYCLES(3), .ERR_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]),
    .fa_a(fa_a[2]), .fa_b(fa_b[2]), .fa_cin(fa_cin[2]), .fa_s(fa_s[2]), .fa_cout(fa_cout[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_cnt(err2),
    .fail_valid(fail_valid[2]), .fail_vec(fvec2));

  // Returns just after the accepting edge (cycle 0 of the run).
  task automatic pulse_start(input int i);
    @(negedge clk);
    start[i] = 1'b1;
    @(posedge clk);
    #1;
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int limit, output int cyc);
    cyc = -1;
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk);
      #1;
      if (done[i]) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = '0; abort = '0;
    mode0 = 2'd0; mode1 = 2'd0; mode2 = 2'd0;
    #12;
    checks++;
    if ({busy, done, pass, fail_valid} !== 12'h000) begin
      failures++; $display("FAIL reset_flags got=%h exp=000", {busy, done, pass, fail_valid});
    end
    checks++;
    if ({fa_a, fa_b, fa_cin} !== 9'h000) begin
      failures++; $display("FAIL reset_fa got=%h exp=000", {fa_a, fa_b, fa_cin});
    end
    checks++;
    if ({err0, err1, err2, fvec0, fvec1, fvec2} !== 19'h0) begin
      failures++; $display("FAIL reset_err got=%h exp=0", {err0, err1, err2, fvec0, fvec1, fvec2});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ((busy | done) !== 3'b000) begin
      failures++; $display("FAIL reset_no_autostart busy=%b done=%b exp=000", busy, done);
    end
  endtask

  task automatic test_correct;
    int bad;
    bad = 0;
    mode0 = 2'd0;
    pulse_start(0);
    for (int c = 0; c < 16; c++) begin
      checks++;
      if ({fa_a[0], fa_b[0], fa_cin[0]} !== 3'(c / 2) || busy[0] !== 1'b1 || done[0] !== 1'b0) begin
        failures++;
        $display("FAIL correct_step c=%0d fa=%b busy=%b done=%b exp_fa=%b", c,
                 {fa_a[0], fa_b[0], fa_cin[0]}, busy[0], done[0], 3'(c / 2));
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (done[0] !== 1'b1 || pass[0] !== 1'b1 || busy[0] !== 1'b0) begin
      failures++; $display("FAIL correct_done done=%b pass=%b busy=%b exp=1 1 0", done[0], pass[0], busy[0]);
    end
    checks++;
    if (err0 !== 4'd0 || fail_valid[0] !== 1'b0 || fvec0 !== 3'b000) begin
      failures++; $display("FAIL correct_err err=%0d fv=%b fvec=%b exp=0 0 000", err0, fail_valid[0], fvec0);
    end
  endtask

  task automatic test_fault(input logic [1:0] m, input logic [3:0] exp_err, input logic [2:0] exp_fvec);
    int cyc;
    mode0 = m;
    pulse_start(0);
    checks++;
    if (done[0] !== 1'b0 || busy[0] !== 1'b1) begin
      failures++; $display("FAIL fault%0d_restart done=%b busy=%b exp=0 1", m, done[0], busy[0]);
    end
    wait_done(0, 40, cyc);
    checks++;
    if (cyc !== 16) begin
      failures++; $display("FAIL fault%0d_latency got=%0d exp=16", m, cyc);
    end
    checks++;
    if (err0 !== exp_err || fvec0 !== exp_fvec || fail_valid[0] !== 1'b1 || pass[0] !== 1'b0) begin
      failures++; $display("FAIL fault%0d_result err=%0d fvec=%b fv=%b pass=%b exp=%0d %b 1 0",
                           m, err0, fvec0, fail_valid[0], pass[0], exp_err, exp_fvec);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    mode0 = 2'd0;
    pulse_start(0);
    checks++;
    if (err0 !== 4'd0 || fail_valid[0] !== 1'b0 || fvec0 !== 3'b000 || done[0] !== 1'b0 || pass[0] !== 1'b0) begin
      failures++; $display("FAIL b2b_clear err=%0d fv=%b fvec=%b done=%b pass=%b exp=0 0 000 0 0",
                           err0, fail_valid[0], fvec0, done[0], pass[0]);
    end
    wait_done(0, 40, cyc);
    checks++;
    if (cyc !== 16 || pass[0] !== 1'b1) begin
      failures++; $display("FAIL b2b_done cyc=%0d pass=%b exp=16 1", cyc, pass[0]);
    end
  endtask

  task automatic test_saturate;
    int cyc;
    mode1 = 2'd3;
    pulse_start(1);
    wait_done(1, 40, cyc);
    checks++;
    if (cyc !== 16 || err1 !== 2'd3 || fvec1 !== 3'b000 || pass[1] !== 1'b0 || fail_valid[1] !== 1'b1) begin
      failures++; $display("FAIL saturate cyc=%0d err=%0d fvec=%b pass=%b fv=%b exp=16 3 000 0 1",
                           cyc, err1, fvec1, pass[1], fail_valid[1]);
    end
  endtask

  task automatic test_restart_ignored;
    int cyc;
    mode2 = 2'd0;
    pulse_start(2);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    start[2] = 1'b1;
    @(posedge clk);
    #1;
    start[2] = 1'b0;
    checks++;
    if ({fa_a[2], fa_b[2], fa_cin[2]} !== 3'b001 || busy[2] !== 1'b1) begin
      failures++; $display("FAIL restart_ignored_vec fa=%b busy=%b exp=001 1", {fa_a[2], fa_b[2], fa_cin[2]}, busy[2]);
    end
    wait_done(2, 60, cyc);
    checks++;
    if (cyc + 5 !== 32 || pass[2] !== 1'b1 || err2 !== 4'd0) begin
      failures++; $display("FAIL restart_ignored_done cyc=%0d pass=%b err=%0d exp=32 1 0", cyc + 5, pass[2], err2);
    end
  endtask

  task automatic test_abort_reset;
    int cyc;
    mode0 = 2'd3;
    pulse_start(0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (err0 !== 4'd2 || fail_valid[0] !== 1'b1 || fvec0 !== 3'b000) begin
      failures++; $display("FAIL abort_pre err=%0d fv=%b fvec=%b exp=2 1 000", err0, fail_valid[0], fvec0);
    end
    abort[0] = 1'b1;
    @(posedge clk);
    #1;
    abort[0] = 1'b0;
    checks++;
    if ({busy[0], done[0], pass[0], fail_valid[0], fa_a[0], fa_b[0], fa_cin[0], err0, fvec0} !== 14'h0) begin
      failures++; $display("FAIL abort_clear got=%h exp=0",
                           {busy[0], done[0], pass[0], fail_valid[0], fa_a[0], fa_b[0], fa_cin[0], err0, fvec0});
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      failures++; $display("FAIL abort_stays_idle busy=%b done=%b exp=0 0", busy[0], done[0]);
    end
    pulse_start(0);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy[0], done[0], pass[0], fail_valid[0], fa_a[0], fa_b[0], fa_cin[0], err0, fvec0} !== 14'h0) begin
      failures++; $display("FAIL midrun_reset got=%h exp=0",
                           {busy[0], done[0], pass[0], fail_valid[0], fa_a[0], fa_b[0], fa_cin[0], err0, fvec0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      failures++; $display("FAIL reset_no_restart busy=%b done=%b exp=0 0", busy[0], done[0]);
    end
    mode0 = 2'd0;
    pulse_start(0);
    wait_done(0, 40, cyc);
    checks++;
    if (cyc !== 16 || pass[0] !== 1'b1 || err0 !== 4'd0) begin
      failures++; $display("FAIL recover cyc=%0d pass=%b err=%0d exp=16 1 0", cyc, pass[0], err0);
    end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_fault(2'd2, 4'd4, 3'b000);
    test_fault(2'd1, 4'd4, 3'b001);
    test_back_to_back();
    test_saturate();
    test_restart_ignored();
    test_abort_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
